qpsk_frame_sync: RTL and testbench



---
 rtl/qpsk_frame_sync.sv | 155 +++++++++++++++
 tb/tb_qpsk_frame_sync.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_frame_sync.sv
// Frame synchroniser for the demodulated QPSK bit stream.
// Hunts for HEADER, collects PAYLOAD_BYTES bytes plus an additive checksum,
// and keeps alignment through isolated bad frames with a flywheel.
module qpsk_frame_sync #(
  parameter logic [7:0]  HEADER        = 8'hcc,
  parameter int unsigned PAYLOAD_BYTES = 3,
  parameter int unsigned LOCK_FRAMES   = 2,
  parameter int unsigned LOSS_FRAMES   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_in,
  input  logic                       bit_vld,
  output logic [8*PAYLOAD_BYTES-1:0] para_out,
  output logic                       frame_vld,
  output logic                       chk_err,
  output logic                       hdr_err,
  output logic                       locked,
  output logic [15:0]                err_cnt
);

  // Payload bytes followed by the checksum byte.
  localparam int unsigned FrameBits = 8 * (PAYLOAD_BYTES + 1);
  localparam int unsigned CntW      = $clog2(FrameBits + 1);

  typedef enum logic [1:0] {StHunt, StRecv, StSync} state_e;

  state_e               state;
  logic [7:0]           window;
  logic [CntW-1:0]      bit_cnt;
  logic [FrameBits-1:0] frame_sr;
  logic [3:0]           good_run;
  logic [3:0]           bad_run;

  logic [7:0]           window_next;
  logic [FrameBits-1:0] frame_next;
  logic [7:0]           sum;
  logic                 last_bit;
  logic                 sync_done;
  logic                 chk_ok;
  logic [3:0]           good_inc;
  logic [3:0]           bad_inc;
  logic                 lose;

  assign window_next = {window[6:0], bit_in};
  assign frame_next  = {frame_sr[FrameBits-2:0], bit_in};
  assign last_bit    = (bit_cnt == CntW'(FrameBits - 1));
  assign sync_done   = (bit_cnt == CntW'(7));
  assign chk_ok      = (sum == frame_next[7:0]);
  assign good_inc    = (good_run == 4'(LOCK_FRAMES)) ? good_run : good_run + 4'd1;
  assign bad_inc     = bad_run + 4'd1;
  // Only a locked receiver counts bad frames towards losing lock.
  assign lose        = locked && (bad_inc == 4'(LOSS_FRAMES));

  // Checksum over the payload including the bit arriving this cycle.
  always_comb begin
    sum = 8'h00;
    for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
      sum = sum + frame_next[8*(i+1) +: 8];
    end
  end

  // Frame FSM with registered pulses, payload, lock and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StHunt;
      window    <= 8'h00;
      bit_cnt   <= '0;
      frame_sr  <= '0;
      good_run  <= 4'd0;
      bad_run   <= 4'd0;
      para_out  <= '0;
      frame_vld <= 1'b0;
      chk_err   <= 1'b0;
      hdr_err   <= 1'b0;
      locked    <= 1'b0;
      err_cnt   <= 16'h0000;
    end else begin
      frame_vld <= 1'b0;
      chk_err   <= 1'b0;
      hdr_err   <= 1'b0;
      if (bit_vld) begin
        unique case (state)
          StHunt: begin
            window <= window_next;
            if (window_next == HEADER) begin
              bit_cnt <= '0;
              state   <= StRecv;
            end
          end
          StRecv: begin
            frame_sr <= frame_next;
            bit_cnt  <= bit_cnt + CntW'(1);
            if (last_bit) begin
              bit_cnt <= '0;
              window  <= 8'h00;
              if (chk_ok) begin
                para_out  <= frame_next[FrameBits-1:8];
                frame_vld <= 1'b1;
                bad_run   <= 4'd0;
                good_run  <= good_inc;
                if (locked || (good_inc == 4'(LOCK_FRAMES))) begin
                  locked <= 1'b1;
                  state  <= StSync;
                end else begin
                  state <= StHunt;
                end
              end else begin
                chk_err  <= 1'b1;
                good_run <= 4'd0;
                if (err_cnt != 16'hffff) err_cnt <= err_cnt + 16'd1;
                if (lose) begin
                  locked  <= 1'b0;
                  bad_run <= 4'd0;
                  state   <= StHunt;
                end else if (locked) begin
                  bad_run <= bad_inc;
                  state   <= StSync;
                end else begin
                  state <= StHunt;
                end
              end
            end
          end
          StSync: begin
            window  <= window_next;
            bit_cnt <= bit_cnt + CntW'(1);
            if (sync_done) begin
              bit_cnt <= '0;
              if (window_next == HEADER) begin
                state <= StRecv;
              end else begin
                hdr_err  <= 1'b1;
                good_run <= 4'd0;
                if (err_cnt != 16'hffff) err_cnt <= err_cnt + 16'd1;
                if (lose) begin
                  locked  <= 1'b0;
                  bad_run <= 4'd0;
                  window  <= 8'h00;
                  state   <= StHunt;
                end else begin
                  // Assume the header slot was corrupted and keep the frame.
                  bad_run <= bad_inc;
                  state   <= StRecv;
                end
              end
            end
          end
          default: state <= StHunt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qpsk_frame_sync.sv
// Self-checking bench for qpsk_frame_sync: scoreboard of expected pulses.
module tb_qpsk_frame_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_vld = 1'b0;
  logic [23:0] para_out;
  logic        frame_vld, chk_err, hdr_err, locked;
  logic [15:0] err_cnt;

  logic        rst1 = 1'b1;
  logic        bit_in1 = 1'b0;
  logic        bit_vld1 = 1'b0;
  logic [7:0]  para_out1;
  logic        frame_vld1, chk_err1, hdr_err1, locked1;
  logic [15:0] err_cnt1;

  int pass_cnt = 0;
  int total_cnt = 0;
  longint cyc = 0;

  typedef struct {
    int          kind;  // 0 frame_vld, 1 chk_err, 2 hdr_err
    logic [23:0] para;
    logic        lck;
    logic [15:0] ec;
    longint      due;
  } exp_t;
  exp_t q[$];

  qpsk_frame_sync dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld),
    .para_out(para_out), .frame_vld(frame_vld), .chk_err(chk_err),
    .hdr_err(hdr_err), .locked(locked), .err_cnt(err_cnt)
  );

  qpsk_frame_sync #(.PAYLOAD_BYTES(1)) dut1 (
    .clk(clk), .rst(rst1), .bit_in(bit_in1), .bit_vld(bit_vld1),
    .para_out(para_out1), .frame_vld(frame_vld1), .chk_err(chk_err1),
    .hdr_err(hdr_err1), .locked(locked1), .err_cnt(err_cnt1)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every pulse pops and checks the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due < cyc) begin
      total_cnt = total_cnt + 1;
      $display("FAIL missed_pulse: kind %0d due cycle %0d, still outstanding at cycle %0d",
               q[0].kind, q[0].due, cyc);
      void'(q.pop_front());
    end
    if (frame_vld || chk_err || hdr_err) begin
      int   k;
      exp_t e;
      k = frame_vld ? 0 : (chk_err ? 1 : 2);
      total_cnt = total_cnt + 1;
      if (q.size() == 0) begin
        $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected", k, cyc);
      end else begin
        e = q.pop_front();
        if (k !== e.kind || cyc !== e.due)
          $display("FAIL pulse_kind_time: got kind %0d cycle %0d, want kind %0d cycle %0d",
                   k, cyc, e.kind, e.due);
        else pass_cnt = pass_cnt + 1;
        total_cnt = total_cnt + 1;
        if (para_out !== e.para)
          $display("FAIL para_out: got %h want %h", para_out, e.para);
        else pass_cnt = pass_cnt + 1;
        total_cnt = total_cnt + 1;
        if (locked !== e.lck)
          $display("FAIL locked_at_pulse: got %b want %b", locked, e.lck);
        else pass_cnt = pass_cnt + 1;
        total_cnt = total_cnt + 1;
        if (err_cnt !== e.ec)
          $display("FAIL err_cnt_at_pulse: got %0d want %0d", err_cnt, e.ec);
        else pass_cnt = pass_cnt + 1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit has_exp,
                           input int kind, input logic [23:0] para, input logic lck,
                           input logic [15:0] ec);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      bit_in  = b[i];
      bit_vld = 1'b1;
      if (i == 0 && has_exp) q.push_back('{kind, para, lck, ec, cyc + 1});
      repeat (gap) begin
        @(negedge clk);
        bit_vld = 1'b0;
      end
    end
  endtask

  // Good frame cc 12 34 56 9c with its expected frame_vld.
  task automatic send_good(input int gap, input logic lck, input logic [15:0] ec);
    send_byte(8'hcc, gap, 0, 0, 0, 0, 0);
    send_byte(8'h12, gap, 0, 0, 0, 0, 0);
    send_byte(8'h34, gap, 0, 0, 0, 0, 0);
    send_byte(8'h56, gap, 0, 0, 0, 0, 0);
    send_byte(8'h9c, gap, 1, 0, 24'h123456, lck, ec);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_vld = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bit_vld = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic check_drained(input string name);
    idle(3);
    total_cnt = total_cnt + 1;
    if (q.size() !== 0) begin
      $display("FAIL %s_drained: %0d expectations left, want 0", name, q.size());
      q.delete();
    end else pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_reset();
    // Reset wins over valid bits presented during it.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bit_vld = 1'b1;
      bit_in  = (i % 2 == 0);
    end
    @(negedge clk);
    bit_vld = 1'b0;
    total_cnt = total_cnt + 1;
    if ({para_out, frame_vld, chk_err, hdr_err, locked, err_cnt} !== 44'h0)
      $display("FAIL reset_outputs: got para %h fv %b ce %b he %b lk %b ec %0d, want all 0",
               para_out, frame_vld, chk_err, hdr_err, locked, err_cnt);
    else pass_cnt = pass_cnt + 1;
    rst = 1'b0;
    idle(2);
    total_cnt = total_cnt + 1;
    if ({para_out, frame_vld, chk_err, hdr_err, locked, err_cnt} !== 44'h0)
      $display("FAIL post_reset_idle: got para %h lk %b ec %0d, want 0", para_out, locked,
               err_cnt);
    else pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_back_to_back_lock();
    do_reset();
    send_good(0, 1'b0, 16'd0);
    send_good(0, 1'b1, 16'd0);
    check_drained("lock");
    total_cnt = total_cnt + 1;
    if (locked !== 1'b1 || err_cnt !== 16'd0)
      $display("FAIL lock_state: got locked %b err_cnt %0d, want 1 0", locked, err_cnt);
    else pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_chk_err();
    do_reset();
    send_good(0, 1'b0, 16'd0);
    send_byte(8'hcc, 0, 0, 0, 0, 0, 0);
    send_byte(8'h12, 0, 0, 0, 0, 0, 0);
    send_byte(8'h34, 0, 0, 0, 0, 0, 0);
    send_byte(8'h56, 0, 0, 0, 0, 0, 0);
    send_byte(8'h9d, 0, 1, 1, 24'h123456, 1'b0, 16'd1);
    // Back in HUNT with good_run cleared: one good frame must not lock.
    send_good(0, 1'b0, 16'd1);
    check_drained("chk_err");
  endtask

  task automatic test_flywheel();
    do_reset();
    send_good(0, 1'b0, 16'd0);
    send_good(0, 1'b1, 16'd0);
    send_byte(8'h4c, 0, 1, 2, 24'h123456, 1'b1, 16'd1);
    send_byte(8'h12, 0, 0, 0, 0, 0, 0);
    send_byte(8'h34, 0, 0, 0, 0, 0, 0);
    send_byte(8'h56, 0, 0, 0, 0, 0, 0);
    send_byte(8'h9c, 0, 1, 0, 24'h123456, 1'b1, 16'd1);
    send_good(0, 1'b1, 16'd1);
    check_drained("flywheel");
  endtask

  task automatic test_loss_of_lock();
    do_reset();
    send_good(0, 1'b0, 16'd0);
    send_good(0, 1'b1, 16'd0);
    for (int f = 1; f <= 3; f++) begin
      send_byte(8'hcc, 0, 0, 0, 0, 0, 0);
      send_byte(8'h12, 0, 0, 0, 0, 0, 0);
      send_byte(8'h34, 0, 0, 0, 0, 0, 0);
      send_byte(8'h56, 0, 0, 0, 0, 0, 0);
      send_byte(8'h00, 0, 1, 1, 24'h123456, (f < 3), 16'(f));
    end
    check_drained("loss");
    total_cnt = total_cnt + 1;
    if (locked !== 1'b0 || err_cnt !== 16'd3)
      $display("FAIL loss_state: got locked %b err_cnt %0d, want 0 3", locked, err_cnt);
    else pass_cnt = pass_cnt + 1;
    // Re-hunt from scratch: one good frame is not enough to relock.
    send_good(0, 1'b0, 16'd3);
    check_drained("relock");
  endtask

  task automatic test_gapped_misaligned();
    logic [2:0] garbage;
    do_reset();
    garbage = 3'b110;
    for (int i = 2; i >= 0; i--) begin
      @(negedge clk);
      bit_in  = garbage[i];
      bit_vld = 1'b1;
      repeat (2) begin
        @(negedge clk);
        bit_vld = 1'b0;
      end
    end
    send_good(2, 1'b0, 16'd0);
    check_drained("gapped");
  endtask

  task automatic test_reset_mid_recv();
    logic [7:0] b;
    @(negedge clk);
    rst1 = 1'b0;
    b = 8'hcc;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      bit_in1 = b[i];
      bit_vld1 = 1'b1;
    end
    b = 8'h5a;
    for (int i = 7; i >= 6; i--) begin
      @(negedge clk);
      bit_in1 = b[i];
    end
    @(negedge clk);
    rst1 = 1'b1;
    bit_in1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    bit_vld1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total_cnt = total_cnt + 1;
      if ({para_out1, frame_vld1, chk_err1, hdr_err1, locked1, err_cnt1} !== 28'h0)
        $display("FAIL mid_reset_quiet: got para %h fv %b ce %b he %b lk %b ec %0d, want 0",
                 para_out1, frame_vld1, chk_err1, hdr_err1, locked1, err_cnt1);
      else pass_cnt = pass_cnt + 1;
      @(negedge clk);
    end
    for (int n = 0; n < 3; n++) begin
      b = (n == 0) ? 8'hcc : 8'h5a;
      for (int i = 7; i >= 0; i--) begin
        @(negedge clk);
        bit_in1 = b[i];
        bit_vld1 = 1'b1;
      end
    end
    @(negedge clk);
    bit_vld1 = 1'b0;
    total_cnt = total_cnt + 1;
    if (frame_vld1 !== 1'b1 || para_out1 !== 8'h5a)
      $display("FAIL mid_reset_next_frame: got fv %b para %h, want 1 5a", frame_vld1,
               para_out1);
    else pass_cnt = pass_cnt + 1;
  endtask

  initial begin
    test_reset();
    test_back_to_back_lock();
    test_chk_err();
    test_flywheel();
    test_loss_of_lock();
    test_gapped_misaligned();
    test_reset_mid_recv();
    idle(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
